// File: rtl/display_pkg.sv
// Shared definitions for the hex/decimal 7-segment display formatter:
// FSM encoding, special glyphs, decimal range limits and the
// double-dabble digit adjust helper.
package display_pkg;

  // Conversion sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_FORMAT = 2'd3
  } state_t;

  // Active-low glyphs that are not hex digits
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  // Largest magnitudes that fit on six digits (negative loses one to the sign)
  localparam logic [32:0] DEC_POS_MAX = 33'd999999;
  localparam logic [32:0] DEC_NEG_MAX = 33'd99999;

  // Double-dabble correction: a BCD digit of 5 or more would carry wrongly
  // after the doubling shift, so pre-add 3.
  function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational nibble to active-low 7-segment decoder, bit order {g,f,e,d,c,b,a}.
module seg7_encode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Glyph lookup for 0-9 and A, b, C, d, E, F
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_formatter.sv
// Drives six active-low 7-segment digits from the 32-bit hex PIO word.
// Hex mode shows bits 23:0 directly; decimal mode shows the word as a signed
// integer using a sequential double-dabble conversion with leading-zero
// blanking, a minus sign and an all-dashes overflow pattern. The display
// registers only change in FORMAT, so a conversion never shows partial results.
// The digit count is fixed at six by the board; NUM_DIGITS documents that and
// sizes the internal buses but the hex0..hex5 ports do not scale with it.
module hex_display_formatter
  import display_pkg::*;
#(
  parameter int BCD_BITS   = 20,
  parameter int NUM_DIGITS = 6
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [31:0] hex_export,
  input  logic        dec_mode,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        busy
);

  localparam logic [4:0] LAST_ITER = 5'(BCD_BITS - 1);

  // Input sample registers
  logic [31:0] in_q_reg;
  logic        mode_q_reg;
  logic        in_valid_reg;

  // Value/mode currently being (or last) converted
  logic [31:0] last_val_reg;
  logic        last_mode_reg;
  logic        shown_valid_reg;

  // Sequencer
  state_t      state_reg;
  state_t      state_next;

  // Conversion datapath
  logic                    sign_reg;
  logic                    ovf_reg;
  logic [BCD_BITS-1:0]     mag_reg;
  logic [4*NUM_DIGITS-1:0] bcd_reg;
  logic [4*NUM_DIGITS-1:0] bcd_adj;
  logic [4:0]              cnt_reg;

  // Display
  logic [7*NUM_DIGITS-1:0] disp_reg;
  logic [7*NUM_DIGITS-1:0] fmt_bus;
  logic [2:0]              msd_idx;
  logic [2:0]              sign_idx;

  // Combinational helpers
  logic        change_pending;
  logic        load_sign;
  logic [32:0] load_mag;
  logic        load_ovf;

  // Capture the PIO word and mode every edge; in_valid marks the first real sample after reset
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      in_q_reg     <= '0;
      mode_q_reg   <= 1'b0;
      in_valid_reg <= 1'b0;
    end else begin
      in_q_reg     <= hex_export;
      mode_q_reg   <= dec_mode;
      in_valid_reg <= 1'b1;
    end
  end

  // A new conversion is needed when nothing has been shown yet or the input moved
  assign change_pending = in_valid_reg &&
                          (!shown_valid_reg ||
                           (in_q_reg != last_val_reg) ||
                           (mode_q_reg != last_mode_reg));

  // Sign/magnitude split in 33 bits so that 0x80000000 negates without wrapping
  assign load_sign = last_val_reg[31];
  assign load_mag  = load_sign ? (33'd0 - {1'b1, last_val_reg}) : {1'b0, last_val_reg};
  assign load_ovf  = (!load_sign && (load_mag > DEC_POS_MAX)) ||
                     ( load_sign && (load_mag > DEC_NEG_MAX));

  // Sequencer state register
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: decimal in range takes the shift path, everything else formats directly
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (change_pending) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (last_mode_reg && !load_ovf) begin
          state_next = ST_SHIFT;
        end else begin
          state_next = ST_FORMAT;
        end
      end
      ST_SHIFT: begin
        if (cnt_reg == LAST_ITER) begin
          state_next = ST_FORMAT;
        end
      end
      ST_FORMAT: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_reg != ST_IDLE);

  genvar gi;

  // Per-digit +3 correction applied before each shift
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dabble
      assign bcd_adj[4*gi +: 4] = dabble_adj(bcd_reg[4*gi +: 4]);
    end
  endgenerate

  // Conversion datapath: latch the job, split sign/magnitude, then shift BCD_BITS times
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      last_val_reg    <= '0;
      last_mode_reg   <= 1'b0;
      shown_valid_reg <= 1'b0;
      sign_reg        <= 1'b0;
      ovf_reg         <= 1'b0;
      mag_reg         <= '0;
      bcd_reg         <= '0;
      cnt_reg         <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (change_pending) begin
            last_val_reg  <= in_q_reg;
            last_mode_reg <= mode_q_reg;
          end
        end
        ST_LOAD: begin
          sign_reg <= load_sign;
          ovf_reg  <= last_mode_reg && load_ovf;
          mag_reg  <= load_mag[BCD_BITS-1:0];
          bcd_reg  <= '0;
          cnt_reg  <= '0;
        end
        ST_SHIFT: begin
          {bcd_reg, mag_reg} <= {bcd_adj, mag_reg} << 1;
          cnt_reg            <= cnt_reg + 5'd1;
        end
        ST_FORMAT: begin
          shown_valid_reg <= 1'b1;
        end
        default: begin
          cnt_reg <= '0;
        end
      endcase
    end
  end

  // Most significant non-zero BCD digit; 0 when the value is zero so '0' still shows
  always_comb begin
    msd_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_reg[4*i +: 4] != 4'd0) begin
        msd_idx = 3'(i);
      end
    end
  end

  assign sign_idx = msd_idx + 3'd1;

  // Per-digit glyph selection: hex nibble, decimal digit, minus, blank or overflow dash
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      localparam logic [2:0] IDX = 3'(gi);
      logic [3:0] nib_sel;
      logic [6:0] enc_seg;
      logic [6:0] glyph;

      assign nib_sel = last_mode_reg ? bcd_reg[4*gi +: 4] : last_val_reg[4*gi +: 4];

      seg7_encode u_seg7_encode (
        .nibble (nib_sel),
        .seg    (enc_seg)
      );

      // Choose what this digit shows once the conversion completes
      always_comb begin
        glyph = SEG_BLANK;
        if (!last_mode_reg) begin
          glyph = enc_seg;
        end else if (ovf_reg) begin
          glyph = SEG_MINUS;
        end else if (IDX <= msd_idx) begin
          glyph = enc_seg;
        end else if (sign_reg && (IDX == sign_idx)) begin
          glyph = SEG_MINUS;
        end
      end

      assign fmt_bus[7*gi +: 7] = glyph;
    end
  endgenerate

  // Display registers: blank on reset, updated all at once in FORMAT
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      disp_reg <= {NUM_DIGITS{SEG_BLANK}};
    end else if (state_reg == ST_FORMAT) begin
      disp_reg <= fmt_bus;
    end
  end

  assign hex0 = disp_reg[6:0];
  assign hex1 = disp_reg[13:7];
  assign hex2 = disp_reg[20:14];
  assign hex3 = disp_reg[27:21];
  assign hex4 = disp_reg[34:28];
  assign hex5 = disp_reg[41:35];

endmodule

// File: tb/tb_hex_display_formatter.sv
`timescale 1ns/1ps
// Self-checking bench for hex_display_formatter: a job-level model of the
// display (value -> expected glyphs, plus conversion latency) is compared
// every cycle, and directed literal checks pin both DUT and model.
module tb_hex_display_formatter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] hex_export = 32'd0;
  logic        dec_mode = 1'b1;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  hex_display_formatter dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .hex_export  (hex_export),
    .dec_mode    (dec_mode),
    .hex0        (hex0),
    .hex1        (hex1),
    .hex2        (hex2),
    .hex3        (hex3),
    .hex4        (hex4),
    .hex5        (hex5),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  logic [41:0] dut_disp;
  assign dut_disp = {hex5, hex4, hex3, hex2, hex1, hex0};

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // What six digits must show for a given word and mode
  function automatic logic [41:0] model_disp(input logic [31:0] v, input logic m);
    logic [41:0] r;
    longint sv, mag;
    int nd;
    r = {6{7'h7F}};
    if (!m) begin
      for (int i = 0; i < 6; i++) r[7*i +: 7] = seg_tab[v[4*i +: 4]];
    end else begin
      sv  = longint'($signed(v));
      mag = (sv < 0) ? -sv : sv;
      if ((sv >= 0 && mag > 999999) || (sv < 0 && mag > 99999)) begin
        r = {6{7'h3F}};
      end else begin
        nd = 0;
        do begin
          r[7*nd +: 7] = seg_tab[int'(mag % 10)];
          mag = mag / 10;
          nd++;
        end while (mag != 0);
        if (sv < 0) r[7*nd +: 7] = 7'h3F;
      end
    end
    return r;
  endfunction

  function automatic bit model_ovf(input logic [31:0] v, input logic m);
    longint sv;
    sv = longint'($signed(v));
    return m && ((sv > 999999) || (sv < -99999));
  endfunction

  // Job-level model: a conversion starts one edge after a changed sample and
  // lands 22 (decimal) or 2 (hex/overflow) edges later
  logic [41:0] m_disp = {6{7'h7F}};
  logic [41:0] m_pending = '0;
  int          m_left = 0;
  bit          m_have_sample = 0;
  bit          m_valid = 0;
  logic [31:0] m_in = '0, m_last_val = '0;
  logic        m_mode = 0, m_last_mode = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_disp = {6{7'h7F}};
      m_left = 0;
      m_have_sample = 0;
      m_valid = 0;
      m_last_val = '0;
      m_last_mode = 0;
    end else begin
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_disp = m_pending;
      end else if (m_have_sample && (!m_valid || m_in != m_last_val || m_mode != m_last_mode)) begin
        m_last_val  = m_in;
        m_last_mode = m_mode;
        m_valid     = 1;
        m_pending   = model_disp(m_in, m_mode);
        m_left      = (m_mode && !model_ovf(m_in, m_mode)) ? 22 : 2;
      end
      m_in = hex_export;
      m_mode = dec_mode;
      m_have_sample = 1;
    end
  end

  // Every-cycle comparison of busy and all digits against the model
  always @(negedge clk) begin
    n_checks++;
    if (busy !== (m_left > 0)) begin
      n_fail++;
      $display("FAIL cycle_busy t=%0t: busy=%b expected=%b", $time, busy, (m_left > 0));
    end
    n_checks++;
    if (dut_disp !== m_disp) begin
      n_fail++;
      $display("FAIL cycle_disp t=%0t: display=%h expected=%h", $time, dut_disp, m_disp);
    end
  end

  task automatic check_digits(input string name, input logic [41:0] exp);
    n_checks++;
    if (dut_disp !== exp) begin
      n_fail++;
      $display("FAIL %s: display=%h expected=%h", name, dut_disp, exp);
    end
    n_checks++;
    if (m_disp !== exp) begin
      n_fail++;
      $display("FAIL %s_model: model=%h expected=%h", name, m_disp, exp);
    end
    $display("check %s: display=%h", name, dut_disp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%b expected=%b", name, act, exp);
    end
    $display("check %s: %b", name, act);
  endtask

  task automatic apply(input logic [31:0] v, input logic m, input int cycles);
    @(negedge clk);
    hex_export = v;
    dec_mode = m;
    repeat (cycles) @(negedge clk);
  endtask

  // Drive a value and verify hex0 is unchanged after lat edges and updated one edge later
  task automatic drive_timed(input string name, input logic [31:0] v, input logic m,
                             input int lat, input logic [6:0] old_h0, input logic [6:0] new_h0);
    @(negedge clk);
    hex_export = v;
    dec_mode = m;
    repeat (lat) @(negedge clk);
    n_checks++;
    if (hex0 !== old_h0) begin
      n_fail++;
      $display("FAIL %s_early: hex0=%h expected=%h", name, hex0, old_h0);
    end
    @(negedge clk);
    n_checks++;
    if (hex0 !== new_h0) begin
      n_fail++;
      $display("FAIL %s_late: hex0=%h expected=%h", name, hex0, new_h0);
    end
    $display("check %s: hex0=%h", name, hex0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    rst = 1'b1;
    hex_export = 32'd0;
    dec_mode = 1'b1;
    repeat (3) @(negedge clk);
    check_digits("reset_blank", {6{7'h7F}});
    check_bit("reset_busy", busy, 1'b0);
    rst = 1'b0;
    // Zero in decimal: exactly 23 edges after the first sample
    repeat (23) @(negedge clk);
    check_digits("zero_not_yet", {6{7'h7F}});
    @(negedge clk);
    check_digits("zero_shown", {{5{7'h7F}}, 7'h40});

    // 123456: busy for exactly 22 cycles
    @(negedge clk);
    hex_export = 32'd123456;
    dec_mode = 1'b1;
    busy_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    n_checks++;
    if (busy_cnt != 22) begin
      n_fail++;
      $display("FAIL busy_len: cycles=%0d expected=22", busy_cnt);
    end
    $display("check busy_len: %0d", busy_cnt);
    check_digits("dec_123456", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});

    // Negative values
    apply(32'hFFFFFFD6, 1'b1, 30);
    check_digits("dec_m42", {7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h19, 7'h24});
    apply(32'hFFFE7961, 1'b1, 30);
    check_digits("dec_m99999", {7'h3F, {5{7'h10}}});

    // Range edges and overflow
    apply(32'd999999, 1'b1, 30);
    check_digits("dec_999999", {6{7'h10}});
    drive_timed("ovf_1000000", 32'd1000000, 1'b1, 3, 7'h10, 7'h3F);
    check_digits("ovf_1000000_all", {6{7'h3F}});
    apply(32'd999999, 1'b1, 30);
    drive_timed("ovf_m100000", 32'hFFFE7960, 1'b1, 3, 7'h10, 7'h3F);
    check_digits("ovf_m100000_all", {6{7'h3F}});
    apply(32'd999999, 1'b1, 30);
    drive_timed("ovf_min_int", 32'h80000000, 1'b1, 3, 7'h10, 7'h3F);
    check_digits("ovf_min_int_all", {6{7'h3F}});

    // Hex mode, then a mode-only change triggers reconversion
    apply(32'h12ABCDEF, 1'b0, 10);
    check_digits("hex_abcdef", {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E});
    @(negedge clk);
    dec_mode = 1'b1;
    repeat (2) @(negedge clk);
    check_bit("mode_toggle_busy", busy, 1'b1);
    repeat (2) @(negedge clk);
    check_digits("mode_toggle_ovf", {6{7'h3F}});
    apply(32'h00000005, 1'b0, 10);
    check_digits("hex_no_blank", {{5{7'h40}}, 7'h12});

    // Input change during SHIFT: first result shown, then the final one
    @(negedge clk);
    hex_export = 32'd5;
    dec_mode = 1'b1;
    repeat (5) @(negedge clk);
    hex_export = 32'd77;
    repeat (19) @(negedge clk);
    check_digits("midshift_first", {{5{7'h7F}}, 7'h12});
    repeat (40) @(negedge clk);
    check_digits("midshift_final", {{4{7'h7F}}, 7'h78, 7'h78});

    // Reset pulse during SHIFT aborts and blanks immediately
    apply(32'd123456, 1'b1, 6);
    #2 rst = 1'b1;
    #1;
    check_digits("midshift_reset_blank", {6{7'h7F}});
    check_bit("midshift_reset_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check_digits("after_reset_redisplay", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
